// File: rtl/riser_pkg.sv
// Shared riser definitions: CPU cycle FSM encoding and SPI port defaults.
// Pure types and constants; no logic, no latency, no flow control.
package riser_pkg;

    localparam int SYNC_STAGES_DEF = 2;
    localparam int BITS_DEF        = 8;

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_WRITE_CAP    = 2'd1,
        ST_READ_DRV     = 2'd2,
        ST_WAIT_AS_HIGH = 2'd3
    } cyc_state_t;

endpackage

// File: rtl/riser_sync.sv
// Single-bit flop-chain synchronizer with a selectable reset value.
// Latency: STAGES clocks from pin to q.
// Backpressure: none; samples every clock.
module riser_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= {STAGES{RST_VAL}};
        end else begin
            chain[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                chain[i] <= chain[i-1];
            end
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/stm_data_port.sv
// Byte mailbox between an STM32 SPI master (mode 0) and 68020 D[31:24] cycles.
// Latency: SYNC_STAGES+2 clocks from the 8th SCK rise to RD_VALID; D_OE one clock after DS20.
// Backpressure: none; a byte arriving while RD_VALID is held is dropped and flags OVERRUN.
module stm_data_port
    import riser_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int BITS        = BITS_DEF
) (
    input  logic            CLKCPU_A,
    input  logic            RESETn,
    input  logic            AS20,
    input  logic            DS20,
    input  logic            RW,
    input  logic            PUNT_OK,
    input  logic [BITS-1:0] D_IN,
    output logic [BITS-1:0] D_OUT,
    output logic            D_OE,
    input  logic            SPI_NSS,
    input  logic            SPI_CK,
    input  logic            SPI_MOSI,
    output logic            SPI_MISO,
    output logic            RD_VALID,
    output logic            OVERRUN
);

    localparam int CW = (BITS > 2) ? $clog2(BITS) : 1;
    localparam int SW = $clog2(SYNC_STAGES + 1) + 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(BITS - 1);

    logic nss_s, sck_s, mosi_s;
    logic nss_d, sck_d, as_d;
    logic sck_rise, sck_fall, as_rise;
    logic frame_act, frame_start;
    logic [SW-1:0] settle;
    logic settled, armed;

    logic [CW-1:0]   bit_cnt;
    logic [BITS-1:0] rx_sh, tx_sh;
    logic            byte_done;

    logic [BITS-1:0] wr_hold, rd_hold;
    logic            rd_vld, ovr;
    logic            read_seen, rd_clr, cpu_sel;
    cyc_state_t      state;

    riser_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_nss (
        .clk(CLKCPU_A), .rst_n(RESETn), .d(SPI_NSS), .q(nss_s)
    );
    riser_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck (
        .clk(CLKCPU_A), .rst_n(RESETn), .d(SPI_CK), .q(sck_s)
    );
    riser_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk(CLKCPU_A), .rst_n(RESETn), .d(SPI_MOSI), .q(mosi_s)
    );

    always_ff @(posedge CLKCPU_A or negedge RESETn) begin
        if (!RESETn) begin
            nss_d <= 1'b1;
            sck_d <= 1'b0;
            as_d  <= 1'b1;
        end else begin
            nss_d <= nss_s;
            sck_d <= sck_s;
            as_d  <= AS20;
        end
    end

    assign sck_rise = sck_s & ~sck_d;
    assign sck_fall = ~sck_s & sck_d;
    assign as_rise  = AS20 & ~as_d;
    assign settled  = (settle == SW'(SYNC_STAGES));

    // The NSS chain resets high, so ignore it until it has flushed and a real
    // high level has been seen; a frame in progress across reset is dropped.
    always_ff @(posedge CLKCPU_A or negedge RESETn) begin
        if (!RESETn) begin
            settle <= '0;
            armed  <= 1'b0;
        end else if (!settled) begin
            settle <= settle + 1'b1;
        end else if (nss_s) begin
            armed <= 1'b1;
        end
    end

    assign frame_act   = armed & ~nss_s;
    assign frame_start = armed & nss_d & ~nss_s;

    always_ff @(posedge CLKCPU_A or negedge RESETn) begin
        if (!RESETn) begin
            bit_cnt   <= '0;
            rx_sh     <= '0;
            tx_sh     <= '0;
            byte_done <= 1'b0;
        end else begin
            byte_done <= 1'b0;
            if (!frame_act) begin
                bit_cnt <= '0;
            end else if (sck_rise) begin
                rx_sh <= {rx_sh[BITS-2:0], mosi_s};
                if (bit_cnt == LAST_BIT) begin
                    bit_cnt   <= '0;
                    byte_done <= 1'b1;
                end else begin
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end
            if (frame_start) begin
                tx_sh <= wr_hold;
            end else if (frame_act && sck_fall) begin
                tx_sh <= {tx_sh[BITS-2:0], 1'b0};
            end
        end
    end

    assign SPI_MISO = tx_sh[BITS-1];

    // rx_sh stays stable for the clock after byte_done: the next SCK rise is
    // at least four clocks away.
    assign rd_clr = as_rise & read_seen;

    always_ff @(posedge CLKCPU_A or negedge RESETn) begin
        if (!RESETn) begin
            rd_hold <= '0;
            rd_vld  <= 1'b0;
            ovr     <= 1'b0;
        end else if (byte_done) begin
            if (!rd_vld || rd_clr) begin
                rd_hold <= rx_sh;
                rd_vld  <= 1'b1;
            end else begin
                ovr <= 1'b1;
            end
        end else if (rd_clr) begin
            rd_vld <= 1'b0;
        end
    end

    assign RD_VALID = rd_vld;
    assign OVERRUN  = ovr;

    assign cpu_sel = ~AS20 & ~DS20 & PUNT_OK;

    always_ff @(posedge CLKCPU_A or negedge RESETn) begin
        if (!RESETn) begin
            state     <= ST_IDLE;
            D_OE      <= 1'b0;
            D_OUT     <= '0;
            wr_hold   <= '0;
            read_seen <= 1'b0;
        end else if (AS20) begin
            state     <= ST_IDLE;
            D_OE      <= 1'b0;
            read_seen <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (cpu_sel) begin
                        if (RW) begin
                            state     <= ST_READ_DRV;
                            D_OE      <= 1'b1;
                            D_OUT     <= rd_hold;
                            read_seen <= 1'b1;
                        end else begin
                            state   <= ST_WRITE_CAP;
                            wr_hold <= D_IN;
                        end
                    end
                end
                ST_WRITE_CAP: state <= ST_WAIT_AS_HIGH;
                ST_READ_DRV: begin
                    if (DS20) begin
                        state <= ST_WAIT_AS_HIGH;
                        D_OE  <= 1'b0;
                    end else begin
                        D_OUT <= rd_hold;
                    end
                end
                ST_WAIT_AS_HIGH: state <= ST_WAIT_AS_HIGH;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/stm_data_port.md
STM_DATA_PORT -- requirements
Module: stm_data_port

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, number of flops in each SPI input synchronizer chain.
REQ-002 SHALL have parameter BITS, default 8, SPI frame width, equal to the CPU byte lane D[31:24].
REQ-003 SHALL have ports: CLKCPU_A in 1, the single clock; RESETn in 1, asynchronous active-low reset.
REQ-004 SHALL have ports AS20 in 1, DS20 in 1, RW in 1: 68020 strobes and direction, all active-low except RW (1 = read).
REQ-005 SHALL have port PUNT_OK in 1: the upstream punt stage has claimed the current CPU cycle.
REQ-006 SHALL have port D_IN in 8: CPU data D[31:24] as sampled from the pins.
REQ-007 SHALL have ports D_OUT out 8 and D_OE out 1: read data and output enable for D[31:24].
REQ-008 SHALL have ports SPI_NSS in 1, SPI_CK in 1, SPI_MOSI in 1: STM32 SPI master, mode 0, MSB first.
REQ-009 SHALL have port SPI_MISO out 1: slave output carrying the latched CPU write byte.
REQ-010 SHALL have ports RD_VALID out 1 (read byte held) and OVERRUN out 1 (sticky, a received byte was dropped).

Function
REQ-011 SHALL pass SPI_NSS, SPI_CK and SPI_MOSI each through a SYNC_STAGES flop chain before any use, with edge detection on the synchronized SPI_CK.
REQ-012 SHALL support SPI_CK up to CLKCPU_A/4; faster SPI_CK is unsupported.
REQ-013 SHALL, while synchronized NSS is high, hold the 3-bit bit counter at 0 and leave the rx shift register contents unchanged.
REQ-014 SHALL, on each synchronized SCK rising edge with NSS low, shift MOSI into the rx shift register LSB, shifting the register left, and increment the bit counter.
REQ-015 SHALL, on each synchronized SCK falling edge with NSS low, shift the tx register left; SPI_MISO SHALL be tx[7].
REQ-016 SHALL, on the NSS falling edge, load tx from wr_hold, so SPI_MISO presents wr_hold[7] before the first SCK rising edge.
REQ-017 SHALL, when the bit counter wraps 7->0, transfer the completed byte to rd_hold and set RD_VALID in the following clock.
REQ-018 SHALL, if a byte completes while RD_VALID=1, discard the new byte, keep rd_hold, and set OVERRUN.
REQ-019 SHALL, on the first clock where AS20=0, DS20=0, RW=0 and PUNT_OK=1, capture D_IN into wr_hold, once per cycle.
REQ-020 SHALL assert D_OE, registered, when AS20=0, DS20=0, RW=1 and PUNT_OK=1, with D_OUT=rd_hold; otherwise D_OE=0.
REQ-021 SHALL, on the AS20 rising edge following a cycle that asserted D_OE, clear RD_VALID.
REQ-022 SHALL, if a byte completes in the same clock that RD_VALID is cleared, load the new byte and keep RD_VALID=1, without setting OVERRUN.
REQ-023 SHALL clear OVERRUN only by reset.
REQ-024 SHALL implement a cycle FSM with states IDLE, WRITE_CAP, READ_DRV and WAIT_AS_HIGH:
- IDLE -> WRITE_CAP or READ_DRV on qualified DS20 low (per REQ-019 / REQ-020).
- WRITE_CAP -> WAIT_AS_HIGH after one clock.
- READ_DRV -> WAIT_AS_HIGH when DS20 goes high.
- WAIT_AS_HIGH -> IDLE when AS20=1.
- Any state -> IDLE if AS20=1.

Reset
REQ-025 SHALL, with RESETn=0, asynchronously force: FSM=IDLE, D_OE=0, D_OUT=0, SPI_MISO=0, RD_VALID=0, OVERRUN=0, wr_hold=0, rd_hold=0, shift registers=0, bit counter=0, synchronizer chains to NSS=1, SCK=0, MOSI=0.
REQ-026 SHALL, on reset during an SPI frame, discard the partial frame; resynchronization SHALL require an NSS high period after release.

Structure
REQ-027 SHALL place the FSM state encoding, BITS and SYNC_STAGES defaults in the shared riser package.
REQ-028 SHALL implement the synchronizer as sub-module riser_sync, instantiated once per SPI input.

Verification
REQ-029 SHALL cover SPI receive: STM32 shifts 0xA5 with NSS low -> RD_VALID=1 within SYNC_STAGES+2 clocks of the 8th SCK rise.
REQ-030 SHALL cover CPU read: claimed read cycle after 0xA5 received -> D_OE=1, D_OUT=0xA5 while DS20 low; RD_VALID=0 after AS20 rises.
REQ-031 SHALL cover CPU write: claimed write of D_IN=0x3C, then a SPI frame -> SPI_MISO bits 0,0,1,1,1,1,0,0.
REQ-032 SHALL cover overrun: two frames 0x11 then 0x22 with no CPU read -> rd_hold=0x11, OVERRUN=1.
REQ-033 SHALL cover the simultaneous case: a frame completes on the AS20-rise clock of a read -> RD_VALID stays 1, rd_hold=new byte, OVERRUN=0.
REQ-034 SHALL cover reset mid-frame: RESETn low after 4 bits, then a full frame 0x5A -> rd_hold=0x5A.
